// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and the cpu: opcode map, NOP word
// and the fetch state encoding.
package cpu_pkg;

    localparam logic [3:0] OP_LDI  = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [15:0] NOP_INSTR = {OP_NOP, 12'h000};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program store: one write port and a registered read port, no reset.
// A same-cycle write to the read address is forwarded to the read register.
module prog_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Forwarding lets a load in the same cycle as start be seen by the first fetch.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks the program store from pc 0 on start, holding
// each word on instr for HOLD_CYCLES cycles, and stops on HALT or end of store.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int INSTR_W     = 16,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [ADDR_W-1:0]  PC_LAST = '1;
    localparam logic [INSTR_W-1:0] NOP_W   = INSTR_W'(NOP_INSTR);

    fetch_state_t       state, state_nxt;
    logic [ADDR_W-1:0]  pc_q, pc_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [INSTR_W-1:0] instr_q, instr_nxt;
    logic               valid_q, valid_nxt;
    logic               mem_we;
    logic [INSTR_W-1:0] mem_rdata;

    assign mem_we = load_en && ((state == ST_IDLE) || (state == ST_HALT));

    // The read address is the next pc, so the word is ready during the FETCH cycle.
    prog_mem #(
        .ADDR_W(ADDR_W),
        .DATA_W(INSTR_W)
    ) u_prog_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(load_addr),
        .wdata(load_data),
        .raddr(pc_nxt),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            instr_q <= NOP_W;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            cnt_q   <= cnt_nxt;
            instr_q <= instr_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        cnt_nxt   = cnt_q;
        instr_nxt = instr_q;
        valid_nxt = valid_q;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = '0;
                end
            end
            ST_FETCH: begin
                if (mem_rdata[INSTR_W-1 -: 4] == OP_HALT) begin
                    state_nxt = ST_HALT;
                    instr_nxt = NOP_W;
                    valid_nxt = 1'b0;
                end else begin
                    state_nxt = ST_ISSUE;
                    instr_nxt = mem_rdata;
                    valid_nxt = 1'b1;
                    cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            ST_ISSUE: begin
                if (cnt_q == '0) begin
                    instr_nxt = NOP_W;
                    valid_nxt = 1'b0;
                    // The last word of the store ends the program; pc never wraps.
                    if (pc_q == PC_LAST) begin
                        state_nxt = ST_HALT;
                    end else begin
                        pc_nxt    = pc_q + ADDR_W'(1);
                        state_nxt = ST_FETCH;
                    end
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = (state == ST_FETCH) || (state == ST_ISSUE);
    assign halted      = (state == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of instr_fetch against a cycle trace computed
// from the program contents.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int AW    = 4;
    localparam int IW    = 16;
    localparam int HOLD  = 2;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;

    instr_fetch #(
        .ADDR_W(AW),
        .INSTR_W(IW),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] word;
        logic [AW-1:0] addr;
        logic          bsy;
        logic          hlt;
    } exp_t;

    int            vectors = 0;
    int            miscompares = 0;
    logic [IW-1:0] model_mem [DEPTH];
    exp_t          trace [$];
    int            final_pc;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle view from the first cycle after start until the halt.
    function automatic void build_trace();
        trace.delete();
        final_pc = DEPTH - 1;
        for (int a = 0; a < DEPTH; a++) begin
            trace.push_back('{valid: 1'b0, word: 16'hE000, addr: AW'(a), bsy: 1'b1, hlt: 1'b0});
            if (model_mem[a][15:12] == 4'hF) begin
                final_pc = a;
                return;
            end
            for (int h = 0; h < HOLD; h++)
                trace.push_back('{valid: 1'b1, word: model_mem[a], addr: AW'(a), bsy: 1'b1, hlt: 1'b0});
        end
    endfunction

    task automatic sample_all(input string tag, input exp_t e);
        check_output({tag, ".valid"},  32'(instr_valid), 32'(e.valid));
        check_output({tag, ".instr"},  32'(instr),       32'(e.word));
        check_output({tag, ".pc"},     32'(pc),          32'(e.addr));
        check_output({tag, ".busy"},   32'(busy),        32'(e.bsy));
        check_output({tag, ".halted"}, 32'(halted),      32'(e.hlt));
    endtask

    task automatic check_reset_values(input string tag);
        sample_all(tag, '{valid: 1'b0, word: 16'hE000, addr: '0, bsy: 1'b0, hlt: 1'b0});
    endtask

    task automatic check_halted(input string tag);
        sample_all(tag, '{valid: 1'b0, word: 16'hE000, addr: AW'(final_pc), bsy: 1'b0, hlt: 1'b1});
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        model_mem[a] = d;
    endtask

    // Starts the program and checks every cycle; optionally loads with start
    // and optionally attempts an ignored load at trace index busy_load.
    task automatic run_program(input string tag, input int busy_load, input bit load_with_start,
                               input logic [AW-1:0] la, input logic [IW-1:0] ld);
        start = 1'b1;
        if (load_with_start) begin
            load_en = 1'b1;
            load_addr = la;
            load_data = ld;
            model_mem[la] = ld;
        end
        build_trace();
        @(posedge clk); #1;
        start = 1'b0;
        load_en = 1'b0;
        foreach (trace[i]) begin
            sample_all($sformatf("%s.c%0d", tag, i), trace[i]);
            if (i == busy_load) begin
                load_en = 1'b1;
                load_addr = 4'd1;
                load_data = 16'h3FFF;
            end
            @(posedge clk); #1;
            load_en = 1'b0;
        end
        check_halted({tag, ".end"});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values("idle");

        load_word(4'd0, 16'h0004);
        load_word(4'd1, 16'h1002);
        load_word(4'd2, 16'h2102);
        load_word(4'd3, 16'h3107);
        load_word(4'd4, 16'hF000);
        run_program("basic", -1, 1'b0, '0, '0);
        check_output("basic.pc4", 32'(pc), 32'd4);

        // Reset dropped during the first hold cycle of the second instruction.
        build_trace();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_all($sformatf("pre_rst.c%0d", i), trace[i]);
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        #2 reset = 1'b0;
        #1 check_reset_values("async_rst");
        @(posedge clk); #1;
        check_reset_values("held_rst");
        reset = 1'b1;
        run_program("after_rst", -1, 1'b0, '0, '0);

        run_program("busy_load", 4, 1'b0, '0, '0);
        run_program("rerun", -1, 1'b0, '0, '0);
        check_output("rerun.addr1", 32'(model_mem[1]), 32'h1002);

        for (int a = 0; a < DEPTH; a++)
            load_word(AW'(a), 16'h3001);
        run_program("full", -1, 1'b0, '0, '0);
        check_output("full.pc15", 32'(pc), 32'd15);

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < DEPTH; a++)
                load_word(AW'(a), {4'($urandom_range(0, 14)), 12'($urandom)});
            if (r % 2 == 1)
                load_word(AW'($urandom_range(1, DEPTH - 1)), 16'hF000 | 16'($urandom_range(0, 4095)));
            run_program($sformatf("rand%0d", r), $urandom_range(1, 3), 1'b1,
                        AW'($urandom_range(0, DEPTH - 1)), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of `cpu`. It holds a loadable program store of 16-bit instructions and a program counter. On `start` it walks the program, presenting each instruction on `instr` for a fixed number of cycles so the single-issue `cpu` can complete it. It stops on a HALT opcode or at the end of the store, and drives a defined NOP encoding whenever no instruction is being issued.

## Interface

Parameters:
- `ADDR_W`, default 4: program store address width; depth is 2^ADDR_W words.
- `INSTR_W`, default 16: instruction width; fixed to the cpu format `[15:12]` opcode, `[11:8]` register, `[7:0]` immediate/address.
- `HOLD_CYCLES`, default 2: cycles each instruction is held valid on `instr`; legal range is ≥1.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low (0 = in reset).
- `load_en`  in  1  program-store write strobe.
- `load_addr`  in  ADDR_W  program-store write address.
- `load_data`  in  INSTR_W  program-store write data.
- `start`  in  1  single-cycle pulse that begins execution from PC 0.
- `instr`  out  INSTR_W  instruction to `cpu`; NOP (16'hE000) when not valid.
- `instr_valid`  out  1  high while `instr` carries a program word.
- `pc`  out  ADDR_W  address of the current or next instruction.
- `busy`  out  1  high in FETCH or ISSUE.
- `halted`  out  1  high in HALT.

## Operation

- Reset values: `instr`=16'hE000, `instr_valid`=0, `pc`=0, `busy`=0, `halted`=0, state IDLE, hold counter 0.
- The program store is not reset, so its contents survive reset.
- States:
  - IDLE: `start` → FETCH with pc=0.
  - FETCH: at the edge, `instr`←mem[pc].
    - If the fetched opcode is 4'hF (HALT): `instr` stays NOP, `instr_valid`=0, → HALT.
    - Otherwise: `instr_valid`←1, hold counter←HOLD_CYCLES-1, → ISSUE.
  - ISSUE: decrement the hold counter each edge. At the edge where the counter is 0: `instr`←NOP, `instr_valid`←0.
    - If pc == 2^ADDR_W-1: → HALT, pc is not incremented.
    - Otherwise: pc←pc+1, → FETCH.
  - HALT: `halted`=1 and pc holds. `start` → FETCH with pc=0 and `halted`←0.
- `load_en` writes mem[load_addr]←load_data only in IDLE or HALT. In FETCH or ISSUE it is silently ignored.
- `start` in FETCH or ISSUE is ignored.
- If `start` and `load_en` occur in the same cycle in IDLE or HALT, the write completes, and the FETCH on the next cycle reads the updated word.
- No arithmetic beyond the pc increment (ADDR_W bits) and the hold counter (`$clog2(HOLD_CYCLES+1)` bits). pc never wraps.
- Opcodes other than HALT pass through unmodified; decoding is the `cpu`'s job.

## Timing

- `start` sampled at edge E0 → FETCH during cycle 1 → first `instr_valid` high after E1.
- Each instruction is valid for exactly HOLD_CYCLES cycles, followed by 1 NOP cycle (the FETCH). The issue period is HOLD_CYCLES+1 cycles.
- A HALT word costs 1 cycle (FETCH). `halted` rises at the edge that samples it.
- Reset asserted mid-operation: all outputs return to reset values immediately, without waiting for `clk`. Deasserting reset gives IDLE. The program is retained.
- `instr` and `instr_valid` are registered outputs with no combinational path from any input.

## Structure

- Shared package `cpu_pkg`, containing:
  - opcode constants OP_LDI=4'h0, OP_ST=4'h1, OP_LD=4'h2, OP_ADDI=4'h3, OP_NOP=4'hE, OP_HALT=4'hF;
  - `NOP_INSTR`=16'hE000;
  - the fetch state enum.
- `cpu` also uses these constants.
- One natural sub-module, `prog_mem`: a single write port, a registered read port, no reset.

## Test plan

1. Reset check: hold `reset`=0 → `instr`=16'hE000, `instr_valid`=0, `pc`=0, `busy`=0, `halted`=0.
2. Basic program: load 0x0004, 0x1002, 0x2102, 0x3107, 0xF000 at addresses 0–4, then pulse `start`.
   - The four words appear in order, each valid for exactly 2 cycles and separated by 1 NOP cycle.
   - Afterwards `halted`=1, `pc`=4, and `instr`=16'hE000.
3. End of store: fill all 16 words with 0x3001, then `start` → 16 issues, then `halted`=1 with `pc`=15 and no wrap to 0.
4. Reset mid-ISSUE: drop `reset` during the second instruction of test 2 → outputs are at reset values before the next edge. A fresh `start` reproduces the identical sequence.
5. Load while busy: `load_en` to address 1 with 0x3FFF during ISSUE. Re-run after halt → address 1 still issues 0x1002.
6. Restart from HALT: `start` while halted → `halted` falls and 0x0004 is issued first.
